register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
Parametrised multi-read-port register file for the pipelined MIPS datapath.
- Configurable read-port count and combinational or registered reads.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register pending scoreboard for hazard detection.
- Multi-cycle background clear sequencer, usable without asserting reset.

Parameters:
DATA, 32, data word width in bits
ADDR, 5, address width; depth = 2**ADDR
NRD, 2, number of read ports (1..4)
RD_REG, 0, 0 = combinational read; 1 = registered read, 1-cycle latency
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_R0, 1, 1 = register 0 reads 0, ignores writes, never pending

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
we  in  1  write enable
wa  in  ADDR  write address
wd  in  DATA  write data
ra  in  NRD*ADDR  packed read addresses; port k = ra[k*ADDR +: ADDR]
rd  out  NRD*DATA  packed read data; port k = rd[k*DATA +: DATA]
pend  out  NRD  pending flag for the register addressed by ra port k
iss_en  in  1  mark register iss_addr pending
iss_addr  in  ADDR  register to mark pending
clr  in  1  start background clear sweep (single-cycle pulse or level)
busy  out  1  clear sweep in progress

Behaviour:
- Reset (rstn=0, asynchronous): all registers 0, all pending bits 0, busy=0, sweep counter 0; in RD_REG=1 mode rd registers 0. Effect is immediate, not clock-dependent.
- Write: at posedge, if we && !busy, reg[wa] <= wd and pend[wa] <= 0. If ZERO_R0 && wa==0, the write is dropped.
- Issue: at posedge, if iss_en && !busy, pend[iss_addr] <= 1. iss_addr==0 with ZERO_R0 is ignored.
- Issue and write to the same address in the same cycle: the set wins, so pend=1 and the data is still written.
- Read, RD_REG=0:
  - rd_k = reg[ra_k], combinational.
  - If BYPASS && we && !busy && wa==ra_k (and not R0 under ZERO_R0), rd_k = wd.
- Read, RD_REG=1:
  - At posedge, rd_k <= the same selected value (write-first).
  - Latency is exactly 1 cycle from ra to rd.
- Reads of register 0 under ZERO_R0 return 0 in all modes.
- pend_k = pend[ra_k], combinational in both modes. If BYPASS && we && !busy && wa==ra_k, pend_k = 0. pend_k is always 0 for R0 under ZERO_R0.
- Clear sequencer FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on posedge with clr=1. Counter is loaded with 0 and busy=1 from the next cycle.
  - In SWEEP, each posedge: reg[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt+1.
  - SWEEP -> IDLE on the edge that clears index 2**ADDR-1. busy is high for exactly 2**ADDR cycles.
  - clr during SWEEP is ignored; there is no restart.
  - During SWEEP, we and iss_en are ignored and bypass is disabled. Reads return current array contents, so already-cleared entries read 0.
  - Reset mid-sweep: immediate return to IDLE, busy=0, full array cleared.
- Counter width is ADDR bits; wrap from 2**ADDR-1 to 0 coincides with the exit from SWEEP.
- Multiple read ports addressing the same register return identical data and pend values.
- No X propagation from unused packed fields. All outputs are driven in every state.

Test Plan:
- Reset then read all ports of registers 0..31 -> rd=0 and pend=0 everywhere. Pulse rstn low mid-run -> array reads 0 within the same cycle.
- Write reg5=0xDEADBEEF, then ra0=5, ra1=0 -> rd0=0xDEADBEEF, rd1=0. Then write reg0=0x1234 -> reg0 still reads 0 (ZERO_R0=1).
- BYPASS=1, RD_REG=0: we=1, wa=7, wd=0xA5A5A5A5, ra0=7 in the same cycle -> rd0=0xA5A5A5A5 before the edge. With RD_REG=1 -> rd0=0xA5A5A5A5 one cycle later.
- Pending: iss_en with iss_addr=9 -> next cycle pend for ra=9 is 1. Then we to wa=9 -> pend drops to 0 combinationally (bypass) and stays 0. Issue and write to 9 in the same cycle -> pend=1 afterwards.
- Clear sweep: fill regs 1..31 with nonzero values, pulse clr -> busy high for exactly 32 cycles. A write to reg3 during the sweep is dropped; after busy falls, all registers read 0 and all pend bits are 0.
- Reset during sweep at count 10 -> busy=0 immediately, all registers 0. A new clr afterwards starts from index 0 and runs the full 32 cycles.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Register file bus: write, issue, clear and read-port signals.
// master drives requests and read addresses; slave returns rd/pend/busy.
interface register_file_mp_if #(
    parameter int DATA = 32,
    parameter int ADDR = 5,
    parameter int NRD  = 2
);
    logic                 we;
    logic [ADDR-1:0]      wa;
    logic [DATA-1:0]      wd;
    logic [NRD*ADDR-1:0]  ra;
    logic [NRD*DATA-1:0]  rd;
    logic [NRD-1:0]       pend;
    logic                 iss_en;
    logic [ADDR-1:0]      iss_addr;
    logic                 clr;
    logic                 busy;

    modport master (
        output we, wa, wd, ra, iss_en, iss_addr, clr,
        input  rd, pend, busy
    );

    modport slave (
        input  we, wa, wd, ra, iss_en, iss_addr, clr,
        output rd, pend, busy
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port register file with pending scoreboard and clear sweep.
// Ports: clk, rstn (async low), bus (slave: we/wa/wd, ra->rd/pend, iss, clr->busy).
module register_file_mp #(
    parameter int DATA    = 32,
    parameter int ADDR    = 5,
    parameter int NRD     = 2,
    parameter int RD_REG  = 0,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic               clk,
    input  logic               rstn,
    register_file_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q;
    logic [ADDR-1:0]     cnt_q;
    logic                busy_q;
    logic [DATA-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]    pend_q;

    logic                wr_ok;
    logic                iss_ok;
    logic [NRD*DATA-1:0] rd_d;
    logic [NRD-1:0]      pend_d;

    assign wr_ok  = bus.we && !busy_q &&
                    !((ZERO_R0 != 0) && (bus.wa == '0));
    assign iss_ok = bus.iss_en && !busy_q &&
                    !((ZERO_R0 != 0) && (bus.iss_addr == '0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.clr) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // counter wrap coincides with the exit
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR{1'b1}}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else if (busy_q) begin
            mem_q[cnt_q]  <= '0;
            pend_q[cnt_q] <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[bus.wa]  <= bus.wd;
                pend_q[bus.wa] <= 1'b0;
            end
            // issue after write: a same-address set wins
            if (iss_ok) begin
                pend_q[bus.iss_addr] <= 1'b1;
            end
        end
    end

    function automatic logic is_zero(logic [ADDR-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    function automatic logic is_hit(logic [ADDR-1:0] a);
        return (BYPASS != 0) && bus.we && !busy_q && (bus.wa == a);
    endfunction

    always_comb begin
        rd_d   = '0;
        pend_d = '0;
        for (int k = 0; k < NRD; k++) begin
            if (is_zero(bus.ra[k*ADDR +: ADDR])) begin
                rd_d[k*DATA +: DATA] = '0;
                pend_d[k]            = 1'b0;
            end else if (is_hit(bus.ra[k*ADDR +: ADDR])) begin
                rd_d[k*DATA +: DATA] = bus.wd;
                pend_d[k]            = 1'b0;
            end else begin
                rd_d[k*DATA +: DATA] = mem_q[bus.ra[k*ADDR +: ADDR]];
                pend_d[k]            = pend_q[bus.ra[k*ADDR +: ADDR]];
            end
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [NRD*DATA-1:0] rd_q;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end
        assign bus.rd = rd_q;
    end else begin : g_rd_comb
        assign bus.rd = rd_d;
    end

    assign bus.pend = pend_d;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Randomized bench for register_file_mp: comb and registered-read DUTs
// share stimulus and are compared against an array-based reference model.
module tb_register_file_mp;
    localparam int DATA  = 32;
    localparam int ADDR  = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    register_file_mp_if #(.DATA(DATA), .ADDR(ADDR), .NRD(NRD)) if0 ();
    register_file_mp_if #(.DATA(DATA), .ADDR(ADDR), .NRD(NRD)) if1 ();

    assign if1.we       = if0.we;
    assign if1.wa       = if0.wa;
    assign if1.wd       = if0.wd;
    assign if1.ra       = if0.ra;
    assign if1.iss_en   = if0.iss_en;
    assign if1.iss_addr = if0.iss_addr;
    assign if1.clr      = if0.clr;

    register_file_mp #(
        .DATA(DATA), .ADDR(ADDR), .NRD(NRD),
        .RD_REG(0), .BYPASS(1), .ZERO_R0(1)
    ) u_comb (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0.slave)
    );

    register_file_mp #(
        .DATA(DATA), .ADDR(ADDR), .NRD(NRD),
        .RD_REG(1), .BYPASS(1), .ZERO_R0(1)
    ) u_regd (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DATA-1:0] m_reg  [DEPTH];
    logic            m_pend [DEPTH];
    logic            m_busy;
    int              m_idx;
    logic [DATA-1:0] exp1   [NRD];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int port_addr(int k);
        return int'(if0.ra[k*ADDR +: ADDR]);
    endfunction

    function automatic logic fwd(int a);
        return !m_busy && if0.we && (int'(if0.wa) == a);
    endfunction

    function automatic logic [DATA-1:0] exp_rd(int a);
        if (a == 0) return '0;
        if (fwd(a)) return if0.wd;
        return m_reg[a];
    endfunction

    function automatic logic exp_pend(int a);
        if (a == 0) return 1'b0;
        if (fwd(a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_idx  = 0;
        for (int k = 0; k < NRD; k++) exp1[k] = '0;
    endtask

    task automatic model_edge();
        int wa;
        int ia;
        wa = int'(if0.wa);
        ia = int'(if0.iss_addr);
        if (m_busy) begin
            m_reg[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            if (m_idx == DEPTH - 1) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end else begin
            if (if0.we && wa != 0) begin
                m_reg[wa]  = if0.wd;
                m_pend[wa] = 1'b0;
            end
            if (if0.iss_en && ia != 0) m_pend[ia] = 1'b1;
            if (if0.clr) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic check_all();
        int a;
        for (int k = 0; k < NRD; k++) begin
            a = port_addr(k);
            chk($sformatf("rd0[%0d] a=%0d", k, a),
                if0.rd[k*DATA +: DATA], exp_rd(a));
            chk($sformatf("pend0[%0d] a=%0d", k, a),
                if0.pend[k], exp_pend(a));
            chk($sformatf("rd1[%0d]", k),
                if1.rd[k*DATA +: DATA], exp1[k]);
            chk($sformatf("pend1[%0d] a=%0d", k, a),
                if1.pend[k], exp_pend(a));
        end
        chk("busy0", if0.busy, m_busy);
        chk("busy1", if1.busy, m_busy);
    endtask

    task automatic step();
        logic [DATA-1:0] nxt [NRD];
        @(negedge clk);
        check_all();
        for (int k = 0; k < NRD; k++) nxt[k] = exp_rd(port_addr(k));
        @(posedge clk);
        model_edge();
        for (int k = 0; k < NRD; k++) exp1[k] = nxt[k];
        #1;
    endtask

    task automatic drive(input logic we, input int wa,
                         input logic [DATA-1:0] wd,
                         input int ra0, input int ra1,
                         input logic iss, input int ia,
                         input logic clr);
        if0.we       = we;
        if0.wa       = ADDR'(wa);
        if0.wd       = wd;
        if0.ra       = {ADDR'(ra1), ADDR'(ra0)};
        if0.iss_en   = iss;
        if0.iss_addr = ADDR'(ia);
        if0.clr      = clr;
    endtask

    task automatic rd_only(input int ra0, input int ra1);
        drive(1'b0, 0, '0, ra0, ra1, 1'b0, 0, 1'b0);
    endtask

    task automatic scan_all();
        for (int i = 0; i < DEPTH; i++) begin
            rd_only(i, DEPTH - 1 - i);
            step();
        end
    endtask

    task automatic count_busy(string tag, input int wr_at);
        int n;
        n = 0;
        while (if0.busy && n < 100) begin
            n++;
            if (n == wr_at) drive(1'b1, 3, 32'h3333_3333, 3, 5, 1'b1, 3, 1'b1);
            else rd_only(n % DEPTH, 3);
            step();
        end
        chk(tag, n, 32);
    endtask

    task automatic async_reset();
        rstn = 1'b0;
        #1;
        chk("rst busy0", if0.busy, 1'b0);
        chk("rst busy1", if1.busy, 1'b0);
        chk("rst rd0", if0.rd, '0);
        chk("rst rd1", if1.rd, '0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        drive(1'b0, 0, '0, 0, 0, 1'b0, 0, 1'b0);
        model_reset();
        #12 rstn = 1'b1;

        scan_all();

        drive(1'b1, 5, 32'hDEAD_BEEF, 5, 0, 1'b0, 0, 1'b0);
        step();
        rd_only(5, 0);
        #1;
        chk("r5 rd0", if0.rd[31:0], 32'hDEAD_BEEF);
        chk("r0 rd1", if0.rd[63:32], 32'h0);
        step();
        drive(1'b1, 0, 32'h1234, 0, 5, 1'b0, 0, 1'b0);
        step();
        rd_only(0, 5);
        #1;
        chk("r0 zero", if0.rd[31:0], 32'h0);
        step();

        drive(1'b1, 7, 32'hA5A5_A5A5, 7, 7, 1'b0, 0, 1'b0);
        #1;
        chk("byp comb", if0.rd[31:0], 32'hA5A5_A5A5);
        step();
        chk("byp regd", if1.rd[31:0], 32'hA5A5_A5A5);
        rd_only(7, 5);
        step();

        drive(1'b0, 0, '0, 9, 9, 1'b1, 9, 1'b0);
        step();
        rd_only(9, 9);
        #1;
        chk("pend set", if0.pend, 2'b11);
        step();
        drive(1'b1, 9, 32'h99, 9, 1, 1'b0, 0, 1'b0);
        #1;
        chk("pend byp", if0.pend[0], 1'b0);
        step();
        rd_only(9, 9);
        #1;
        chk("pend clr", if0.pend, 2'b00);
        step();
        drive(1'b1, 9, 32'h9999, 9, 9, 1'b1, 9, 1'b0);
        step();
        rd_only(9, 9);
        #1;
        chk("pend win", if0.pend, 2'b11);
        step();

        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b1, i, 32'h100 + i, i, 0, i[0], i, 1'b0);
            step();
        end
        drive(1'b0, 0, '0, 4, 9, 1'b0, 0, 1'b1);
        step();
        count_busy("sweep len", 10);
        rd_only(3, 9);
        #1;
        chk("r3 dropped", if0.rd[31:0], 32'h0);
        scan_all();

        for (int i = 1; i < 8; i++) begin
            drive(1'b1, i, 32'hC0DE_0000 + i, i, 5, 1'b1, i + 8, 1'b0);
            step();
        end
        drive(1'b0, 0, '0, 5, 6, 1'b0, 0, 1'b1);
        step();
        for (int i = 0; i < 10; i++) begin
            rd_only(5, 6);
            step();
        end
        async_reset();
        rd_only(5, 12);
        step();
        drive(1'b0, 0, '0, 5, 12, 1'b0, 0, 1'b1);
        step();
        count_busy("sweep2 len", 0);
        scan_all();

        for (int c = 0; c < 600; c++) begin
            int wa;
            int r0;
            int r1;
            wa = $urandom_range(0, DEPTH - 1);
            r0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            r1 = ($urandom_range(0, 3) == 0) ? r0 : $urandom_range(0, DEPTH - 1);
            drive(1'($urandom_range(0, 1)), wa, $urandom, r0, r1,
                  1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1),
                  1'($urandom_range(0, 79) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
